turbo_iter_ctrl: RTL and testbench

Iteration scheduler for the turbo decoder datapath. It accepts one frame at a time and sequences the two constituent SOVA decoders (dec1, then dec2) through half-iterations. During each half-iteration it sweeps the shared 4-lane symbol/extrinsic memory address. It stops on an iteration limit or an early-stop match, then streams the decoded frame out under a valid/ready handshake.

---
 rtl/turbo_iter_ctrl.sv | 162 ++++++++++++++++
 tb/tb_turbo_iter_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_iter_ctrl.sv
// turbo_iter_ctrl: schedules dec1/dec2 half-iterations with a shared address sweep, then streams the decoded frame.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module turbo_iter_ctrl #(
    parameter int MAX_ITER  = 8,
    parameter int BLK_WORDS = 256,
    parameter int AW        = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frm_valid,
    output logic          frm_ready,
    input  logic [3:0]    iter_lim,
    output logic          dec_start,
    output logic          dec_sel,
    output logic          addr_en,
    output logic [AW-1:0] addr,
    input  logic          dec_done,
    input  logic          hard_match,
    output logic [3:0]    iter_cnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          err
);

    localparam int            WW        = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(BLK_WORDS - 1);
    localparam logic [WW-1:0] TO_LAST   = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        D1_RUN  = 3'd1,
        D1_WAIT = 3'd2,
        D2_RUN  = 3'd3,
        D2_WAIT = 3'd4,
        OUT     = 3'd5
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    lim, lim_nx, lim_req, iter_nx, iter_inc;
    logic [AW-1:0] addr_nx, out_addr_nx;
    logic [WW-1:0] wait_cnt, wait_cnt_nx;
    logic          err_nx, stop_now, run_nx;

    always_comb begin
        lim_req = iter_lim;
        if (iter_lim == 4'd0) begin
            lim_req = 4'd1;
        end else if (int'(iter_lim) > MAX_ITER) begin
            lim_req = 4'(MAX_ITER);
        end
    end

    assign iter_inc = (iter_cnt == 4'hF) ? 4'hF : iter_cnt + 4'd1;
    // A match on the very first iteration has no previous decision set to compare against.
    assign stop_now = (({1'b0, iter_cnt} + 5'd1) == {1'b0, lim}) ||
                      (hard_match && (iter_cnt != 4'd0));
    assign run_nx   = (state_nx == D1_RUN) || (state_nx == D2_RUN);

    always_comb begin
        state_nx    = state;
        lim_nx      = lim;
        iter_nx     = iter_cnt;
        err_nx      = err;
        addr_nx     = addr;
        out_addr_nx = out_addr;
        wait_cnt_nx = wait_cnt;
        case (state)
            IDLE: begin
                if (frm_valid) begin
                    lim_nx   = lim_req;
                    iter_nx  = 4'd0;
                    err_nx   = 1'b0;
                    addr_nx  = '0;
                    state_nx = D1_RUN;
                end
            end
            D1_RUN, D2_RUN: begin
                if (addr == LAST_ADDR) begin
                    addr_nx     = '0;
                    wait_cnt_nx = '0;
                    state_nx    = (state == D1_RUN) ? D1_WAIT : D2_WAIT;
                end else begin
                    addr_nx = addr + 1'b1;
                end
            end
            D1_WAIT, D2_WAIT: begin
                if (dec_done) begin
                    if (state == D1_WAIT) begin
                        state_nx = D2_RUN;
                    end else begin
                        iter_nx     = iter_inc;
                        out_addr_nx = '0;
                        state_nx    = stop_now ? OUT : D1_RUN;
                    end
                end else if (wait_cnt == TO_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (out_addr == LAST_ADDR) begin
                        out_addr_nx = '0;
                        state_nx    = IDLE;
                    end else begin
                        out_addr_nx = out_addr + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Every output is a flop loaded from next-state values, so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lim       <= 4'd1;
            iter_cnt  <= 4'd0;
            err       <= 1'b0;
            addr      <= '0;
            out_addr  <= '0;
            wait_cnt  <= '0;
            frm_ready <= 1'b1;
            busy      <= 1'b0;
            dec_start <= 1'b0;
            dec_sel   <= 1'b0;
            addr_en   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nx;
            lim       <= lim_nx;
            iter_cnt  <= iter_nx;
            err       <= err_nx;
            addr      <= addr_nx;
            out_addr  <= out_addr_nx;
            wait_cnt  <= wait_cnt_nx;
            frm_ready <= (state_nx == IDLE);
            busy      <= (state_nx != IDLE);
            dec_start <= run_nx && (state_nx != state);
            dec_sel   <= (state_nx == D2_RUN) || (state_nx == D2_WAIT);
            addr_en   <= run_nx;
            out_valid <= (state_nx == OUT);
            out_last  <= (state_nx == OUT) && (out_addr_nx == LAST_ADDR);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_turbo_iter_ctrl.sv
// tb_turbo_iter_ctrl: vector table, hand sequences and random frames for turbo_iter_ctrl.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_turbo_iter_ctrl;

    localparam int MAX_ITER = 8;
    localparam int BLK      = 256;
    localparam int AW       = 8;
    localparam int TO       = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frm_valid = 1'b0;
    logic          frm_ready;
    logic [3:0]    iter_lim = 4'd0;
    logic          dec_start, dec_sel, addr_en;
    logic [AW-1:0] addr;
    logic          dec_done = 1'b0;
    logic          hard_match = 1'b0;
    logic [3:0]    iter_cnt;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_addr;
    logic          out_last, busy, err;

    int n_checks  = 0;
    int n_fail    = 0;
    int start_cnt = 0;
    int frame_bad = 0;

    typedef struct {
        logic [3:0]  lim;
        logic [15:0] mask;
        int          lat;
        bit          spur;
        bit          bp;
        int          exp_n;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    turbo_iter_ctrl #(
        .MAX_ITER (MAX_ITER),
        .BLK_WORDS(BLK),
        .AW       (AW),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frm_valid (frm_valid),
        .frm_ready (frm_ready),
        .iter_lim  (iter_lim),
        .dec_start (dec_start),
        .dec_sel   (dec_sel),
        .addr_en   (addr_en),
        .addr      (addr),
        .dec_done  (dec_done),
        .hard_match(hard_match),
        .iter_cnt  (iter_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always @(negedge clk) begin
        if (dec_start === 1'b1) start_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Number of full iterations the frame should run, from the limit and early-stop rules.
    function automatic int model_iters(input int lim, input logic [15:0] mask);
        int le;
        le = (lim == 0) ? 1 : ((lim > MAX_ITER) ? MAX_ITER : lim);
        for (int i = 1; i <= le; i++) begin
            if (i == le || (mask[i-1] && i >= 2)) return i;
        end
        return le;
    endfunction

    task automatic accept(input logic [3:0] lim);
        check("frm_ready_idle", int'(frm_ready), 1);
        frm_valid = 1'b1;
        iter_lim  = lim;
        @(negedge clk);
        frm_valid = 1'b0;
        iter_lim  = 4'($urandom);
    endtask

    task automatic sweep(input logic sel, input bit spur);
        for (int k = 0; k < BLK; k++) begin
            if (dec_start !== (k == 0) || addr !== AW'(k) || addr_en !== 1'b1 ||
                dec_sel !== sel || busy !== 1'b1) frame_bad++;
            dec_done   = spur && (k == 5);
            hard_match = 1'($urandom);
            @(negedge clk);
        end
        dec_done = 1'b0;
        if (addr_en !== 1'b0 || addr !== '0 || dec_start !== 1'b0 || dec_sel !== sel) frame_bad++;
    endtask

    task automatic wait_done(input int lat, input logic sel, input logic hm);
        for (int i = 0; i < lat; i++) begin
            if (dec_start !== 1'b0 || addr_en !== 1'b0 || busy !== 1'b1 || dec_sel !== sel) frame_bad++;
            dec_done   = 1'b0;
            hard_match = 1'($urandom);
            @(negedge clk);
        end
        dec_done   = 1'b1;
        hard_match = sel ? hm : 1'($urandom);
        @(negedge clk);
        dec_done   = 1'b0;
        hard_match = 1'b0;
    endtask

    task automatic run_frame(input logic [3:0] lim, input logic [15:0] mask, input int lat,
                             input bit spur, input bit bp, input int exp_n);
        int s0;
        int idx;
        int bad;
        int cyc;
        s0        = start_cnt;
        frame_bad = 0;
        accept(lim);
        check("err_clear", int'(err), 0);
        check("iter_clear", int'(iter_cnt), 0);
        for (int it = 1; it <= exp_n; it++) begin
            sweep(1'b0, spur && it == 1);
            wait_done(lat, 1'b0, 1'b0);
            sweep(1'b1, 1'b0);
            wait_done(lat, 1'b1, mask[it-1]);
        end
        check("sweeps", frame_bad, 0);
        check("out_entry", int'(out_valid), 1);
        check("iter_at_out", int'(iter_cnt), exp_n);
        idx = 0;
        bad = 0;
        cyc = 0;
        while (idx < BLK && cyc < 4096) begin
            if (out_valid !== 1'b1 || out_addr !== AW'(idx) || out_last !== (idx == BLK - 1)) bad++;
            out_ready = bp ? 1'($urandom) : 1'b1;
            if (out_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("out_stream", bad, 0);
        check("handshakes", idx, BLK);
        check("idle_after_out", int'({frm_ready, out_valid, busy}), 4);
        check("iter_final", int'(iter_cnt), exp_n);
        check("start_pulses", start_cnt - s0, 2 * exp_n);
    endtask

    initial begin
        tbl[0] = '{4'd3,  16'h0000, 12, 1'b0, 1'b0, 3};
        tbl[1] = '{4'd8,  16'h0005,  4, 1'b0, 1'b0, 3};
        tbl[2] = '{4'd0,  16'h0000,  3, 1'b0, 1'b0, 1};
        tbl[3] = '{4'd12, 16'h0000,  0, 1'b0, 1'b0, 8};
        tbl[4] = '{4'd1,  16'h0001,  2, 1'b0, 1'b0, 1};
        tbl[5] = '{4'd5,  16'h0001,  1, 1'b1, 1'b0, 5};
        tbl[6] = '{4'd4,  16'h0002,  6, 1'b0, 1'b1, 2};
        tbl[7] = '{4'd2,  16'h0000,  9, 1'b1, 1'b1, 2};

        repeat (2) @(negedge clk);
        check("reset_outputs",
              int'({frm_ready, dec_start, dec_sel, addr_en, addr, iter_cnt,
                    out_valid, out_addr, out_last, busy, err}), 28'h8000000);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("no_start_before_frame", start_cnt, 0);
        check("ready_after_reset", int'({frm_ready, busy}), 2);

        for (int v = 0; v < 8; v++) begin
            run_frame(tbl[v].lim, tbl[v].mask, tbl[v].lat, tbl[v].spur, tbl[v].bp, tbl[v].exp_n);
        end

        // Timeout: dec_done withheld in D2_WAIT of iteration 2.
        frame_bad = 0;
        accept(4'd5);
        sweep(1'b0, 1'b0);
        wait_done(3, 1'b0, 1'b0);
        sweep(1'b1, 1'b0);
        wait_done(3, 1'b1, 1'b0);
        sweep(1'b0, 1'b0);
        wait_done(3, 1'b0, 1'b0);
        sweep(1'b1, 1'b0);
        check("to_sweeps", frame_bad, 0);
        check("to_iter_cnt", int'(iter_cnt), 1);
        for (int i = 0; i < TO; i++) begin
            if (busy !== 1'b1 || err !== 1'b0 || frm_ready !== 1'b0) frame_bad++;
            @(negedge clk);
        end
        check("to_waiting", frame_bad, 0);
        check("to_err_idle", int'({err, frm_ready, busy}), 6);
        @(negedge clk);
        check("to_err_sticky", int'(err), 1);

        for (int r = 0; r < 4; r++) begin
            logic [3:0]  l;
            logic [15:0] m;
            l = 4'($urandom_range(0, 15));
            m = 16'($urandom);
            run_frame(l, m, $urandom_range(0, 12), 1'($urandom), 1'($urandom), model_iters(int'(l), m));
        end

        // Reset mid-frame during D2_RUN at addr 100.
        frame_bad = 0;
        accept(4'd3);
        sweep(1'b0, 1'b0);
        wait_done(2, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check("mid_addr", int'({dec_sel, addr}), 9'h100 | 100);
        #1 rst = 1'b0;
        #1;
        check("mid_reset_outputs",
              int'({frm_ready, dec_start, dec_sel, addr_en, addr, iter_cnt,
                    out_valid, out_addr, out_last, busy, err}), 28'h8000000);
        @(negedge clk);
        rst = 1'b1;
        begin
            int s0;
            s0 = start_cnt;
            repeat (6) @(negedge clk);
            check("no_start_after_reset", start_cnt - s0, 0);
        end
        check("idle_after_reset", int'({frm_ready, busy}), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
